link_master_burst: RTL

// Parametrised 4-phase req/ack link master. One start pulse sends a burst of 1..MAX_BURST beats.

---
 rtl/link_master_burst.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/link_master_burst.sv
`default_nettype none
// ============================================================================
// Module   : link_master_burst
// Purpose  : 4-phase req/ack link master. A start pulse sends a burst of
//            1..MAX_BURST beats to the link slave. Beat words come from an
//            incrementing pattern (BASE_VAL + beat index, modulo 2^DATA_W) or
//            from an upstream source (data_in, acknowledged by data_rd).
//            An optional ack timeout parks the block in an error state with a
//            sticky flag until software clears it.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_sig     in   1       clock, rising edge
//   rst_n       in   1       synchronous active-low reset
//   start       in   1       begin a burst (sampled only when idle)
//   len_in      in   CNT_W   beats in the burst, sampled with start
//   data_in     in   DATA_W  next beat word when DATA_SRC = 1
//   data_rd     out  1       pulse: data_in was consumed at the last edge
//   ack_in      in   1       slave acknowledge
//   req_out     out  1       request to slave
//   data_bus    out  DATA_W  beat data (0 when no beat is offered)
//   busy        out  1       high whenever the master is not idle
//   beat_idx    out  CNT_W   index of the current beat
//   finished    out  1       one-cycle pulse at the end of a burst
//   timeout_err out  1       sticky ack-timeout flag
//   err_clr     in   1       leave the error state (needs ack_in low)
// ============================================================================
module link_master_burst #(
  parameter int                DATA_W      = 8,
  parameter int                MAX_BURST   = 4,
  parameter logic [DATA_W-1:0] BASE_VAL    = 8'hA0,
  parameter int                DATA_SRC    = 0,
  parameter int                ACK_TIMEOUT = 0,
  localparam int               CNT_W       = $clog2(MAX_BURST + 1)
) (
  input  logic              clk_sig,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_rd,
  input  logic              ack_in,
  output logic              req_out,
  output logic [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_idx,
  output logic              finished,
  output logic              timeout_err,
  input  logic              err_clr
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int TMO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  // The counter starts at 0 on entry to a waiting state, so the timeout fires
  // on the edge where it already holds ACK_TIMEOUT-1: exactly ACK_TIMEOUT
  // cycles after the state was entered.
  localparam logic [TMO_W-1:0] c_tmo_last = (ACK_TIMEOUT > 0) ? TMO_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] c_max_len  = CNT_W'(MAX_BURST);
  localparam logic             c_tmo_en   = (ACK_TIMEOUT > 0);
  localparam logic             c_ext_src  = (DATA_SRC != 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_LOW = 3'd2,
    S_DONE     = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  w_len_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [TMO_W-1:0]  w_tmo_nxt;

  logic              w_req_nxt;
  logic              w_rd_nxt;
  logic              w_busy_nxt;
  logic              w_fin_nxt;
  logic              w_err_nxt;
  logic [DATA_W-1:0] w_bus_nxt;
  logic [CNT_W-1:0]  w_idx_nxt;

  logic [CNT_W-1:0]  w_load_idx;   // index of the word loaded at this edge
  logic [DATA_W-1:0] w_load_word;  // word for that index
  logic              w_len_ok;
  logic              w_tmo_hit;
  logic              w_last_beat;

  // --------------------------------------------------------------------------
  // Beat word source
  // --------------------------------------------------------------------------
  // A load from IDLE is always beat 0; a load from WAIT_LOW is the next beat.
  assign w_load_idx = (r_state == S_IDLE) ? '0 : beat_idx + CNT_W'(1);

  generate
    if (DATA_SRC != 0) begin : g_src_ext
      logic w_unused_idx;
      assign w_unused_idx = ^w_load_idx;
      assign w_load_word  = data_in;
    end else begin : g_src_pat
      logic w_unused_data;
      assign w_unused_data = ^data_in;
      // Plain modular addition: the pattern wraps past 2^DATA_W-1.
      assign w_load_word   = BASE_VAL + DATA_W'(w_load_idx);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Qualifiers
  // --------------------------------------------------------------------------
  assign w_len_ok    = (len_in != '0) && (len_in <= c_max_len);
  assign w_tmo_hit   = c_tmo_en && (r_tmo_cnt == c_tmo_last);
  assign w_last_beat = (beat_idx == (r_len - CNT_W'(1)));

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_req_nxt   = req_out;
    w_bus_nxt   = data_bus;
    w_idx_nxt   = beat_idx;
    w_rd_nxt    = 1'b0;
    w_fin_nxt   = 1'b0;
    w_err_nxt   = timeout_err;

    unique case (r_state)
      S_IDLE: begin
        // ack_in is deliberately not looked at here.
        if (start && w_len_ok) begin
          w_state_nxt = S_REQ;
          w_len_nxt   = len_in;
          w_idx_nxt   = '0;
          w_req_nxt   = 1'b1;
          w_bus_nxt   = w_load_word;
          w_rd_nxt    = c_ext_src;
        end
      end

      S_REQ: begin
        // A real acknowledge wins over a timeout landing on the same edge.
        if (ack_in) begin
          w_state_nxt = S_WAIT_LOW;
          w_req_nxt   = 1'b0;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
          w_req_nxt   = 1'b0;
          w_bus_nxt   = '0;
          w_err_nxt   = 1'b1;
        end
      end

      S_WAIT_LOW: begin
        if (!ack_in) begin
          if (w_last_beat) begin
            w_state_nxt = S_DONE;
            w_fin_nxt   = 1'b1;
            w_bus_nxt   = '0;
          end else begin
            w_state_nxt = S_REQ;
            w_idx_nxt   = beat_idx + CNT_W'(1);
            w_req_nxt   = 1'b1;
            w_bus_nxt   = w_load_word;
            w_rd_nxt    = c_ext_src;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
          w_req_nxt   = 1'b0;
          w_bus_nxt   = '0;
          w_err_nxt   = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end

      S_ERR: begin
        // Only return once the slave has released ack, so a late ack cannot
        // be mistaken for the first handshake of the next burst.
        if (err_clr && !ack_in) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b0;
          w_idx_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_bus_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);

    // Timeout counter restarts on every state change and only runs while
    // waiting on the slave.
    if (w_state_nxt != r_state) begin
      w_tmo_nxt = '0;
    end else if (c_tmo_en && ((r_state == S_REQ) || (r_state == S_WAIT_LOW))) begin
      w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
    end else begin
      w_tmo_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sig) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_tmo_cnt   <= '0;
      req_out     <= 1'b0;
      data_bus    <= '0;
      data_rd     <= 1'b0;
      busy        <= 1'b0;
      beat_idx    <= '0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      req_out     <= w_req_nxt;
      data_bus    <= w_bus_nxt;
      data_rd     <= w_rd_nxt;
      busy        <= w_busy_nxt;
      beat_idx    <= w_idx_nxt;
      finished    <= w_fin_nxt;
      timeout_err <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire
